// File: rtl/img_pkg.sv
// Shared frame geometry, default UART bit timing and frame FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package img_pkg;

  localparam int IMG_W        = 100;
  localparam int IMG_H        = 100;
  localparam int ADDR_W       = 14;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, data LSB first, stop bit, each CLKS_PER_BIT clk.
// Latency: tx goes low on the clk edge that samples go; byte_done pulses in the last stop-bit clk.
// Backpressure: go is ignored while busy; the caller waits for byte_done.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = img_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end   = busy && (baud_cnt == BAUD_LAST);
  // Combinational so the frame FSM can fetch the next pixel in the same clk the stop bit ends
  assign byte_done = bit_end && (bit_cnt == 4'd9);

  // Bit timing and shifting; tx idles high and is forced high by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (!busy) begin
      if (go) begin
        busy     <= 1'b1;
        tx       <= 1'b0;
        shreg    <= data;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy    <= 1'b0;
        tx      <= 1'b1;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_uart_sender.sv
// Streams a processed frame from the output RAM over UART, row-major, one 8N1 byte per pixel.
// Latency: first start bit 3 clk after the launch edge; 10*CLKS_PER_BIT+3 clk per pixel.
// Backpressure: none; the next RAM read is issued only when the previous byte has left.
module frame_uart_sender #(
  parameter int IMG_W        = img_pkg::IMG_W,
  parameter int IMG_H        = img_pkg::IMG_H,
  parameter int ADDR_W       = img_pkg::ADDR_W,
  parameter int CLKS_PER_BIT = img_pkg::CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  import img_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state;
  logic              start_d;
  logic              launch;
  logic [ADDR_W-1:0] index;
  logic              frame_busy;
  logic              ser_go;
  logic              ser_busy;
  logic              ser_byte_done;

  assign launch  = start & ~start_d;
  assign rd_addr = index;
  assign busy    = frame_busy | ser_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .go        (ser_go),
    .data      (rd_data),
    .tx        (tx),
    .busy      (ser_busy),
    .byte_done (ser_byte_done)
  );

  // Frame sequencing: fetch a pixel, wait for RAM, hand it to the serializer, repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_d    <= 1'b0;
      rd_en      <= 1'b0;
      index      <= '0;
      frame_busy <= 1'b0;
      done       <= 1'b0;
      ser_go     <= 1'b0;
    end else begin
      start_d <= start;
      rd_en   <= 1'b0;
      ser_go  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // Only a fresh edge re-launches; a start left high after done does nothing
          if (launch) begin
            state      <= ST_FETCH;
            index      <= '0;
            frame_busy <= 1'b1;
            done       <= 1'b0;
            rd_en      <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          state  <= ST_LOAD;
          ser_go <= 1'b1;
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: begin
          if (ser_byte_done) begin
            if (index == LAST_IDX) begin
              state      <= ST_DONE;
              frame_busy <= 1'b0;
              done       <= 1'b1;
            end else begin
              state <= ST_FETCH;
              index <= index + 1'b1;
              rd_en <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_sender.sv
// Bench for frame_uart_sender on a 4x4 frame at 4 clk per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_uart_sender;

  localparam int W          = 4;
  localparam int H          = 4;
  localparam int AW         = 4;
  localparam int CPB        = 4;
  localparam int NPIX       = W * H;
  localparam int BYTE_CLKS  = 10 * CPB + 3;
  localparam int FRAME_CLKS = NPIX * BYTE_CLKS;
  localparam int NREC       = FRAME_CLKS + 12;
  localparam int MAXC       = 2100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          tx, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ram [NPIX];
  logic tx_s [MAXC];
  logic done_s [MAXC];
  logic busy_s [MAXC];
  int   addr_q [$];

  frame_uart_sender #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Output RAM: one clk read latency
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // Expected tx, j clk after the launch edge: 3 idle clk, then per byte 10 bits + 3 clk gap
  function automatic logic exp_tx(input int j);
    int p, b, off, bi;
    p = j - 3;
    if (p < 0) return 1'b1;
    b   = p / BYTE_CLKS;
    off = p % BYTE_CLKS;
    if (b >= NPIX || off >= 10 * CPB) return 1'b1;
    bi = off / CPB;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return ram[b][bi-1];
  endfunction

  function automatic int tx_mismatches(input int n, output int first_bad);
    int c = 0;
    first_bad = -1;
    for (int j = 0; j < n; j++)
      if (tx_s[j] !== exp_tx(j)) begin c++; if (first_bad < 0) first_bad = j; end
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int j = 0; j < n; j++) if (done_s[j] === 1'b1) return j;
    return -1;
  endfunction

  function automatic int busy_errs(input int n);
    int c = 0;
    for (int j = 0; j < n; j++) if (busy_s[j] !== (j < FRAME_CLKS)) c++;
    return c;
  endfunction

  function automatic int addr_errs();
    int c = 0;
    if (addr_q.size() != NPIX) return 1000 + addr_q.size();
    for (int i = 0; i < NPIX; i++) if (addr_q[i] != i) c++;
    return c;
  endfunction

  // Sample outputs on the falling edge; optionally glitch start low then high again
  task automatic record(input int n, input int g_at, input int g_len);
    addr_q.delete();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      tx_s[j] = tx; done_s[j] = done; busy_s[j] = busy;
      if (rd_en === 1'b1) addr_q.push_back(int'(rd_addr));
      if (j == g_at) start = 1'b0;
      if (j == g_at + g_len) start = 1'b1;
    end
  endtask

  // Drop start for a few clk, then raise it; returns just after the launch edge
  task automatic launch(input int low_clks);
    @(negedge clk); start = 1'b0;
    repeat (low_clks) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++; if (tx !== 1'b1)    begin tests_failed++; $display("FAIL reset_tx cyc %0d got %b exp 1", i, tx); end
      tests_run++; if (busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy cyc %0d got %b exp 0", i, busy); end
      tests_run++; if (done !== 1'b0)  begin tests_failed++; $display("FAIL reset_done cyc %0d got %b exp 0", i, done); end
      tests_run++; if (rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en cyc %0d got %b exp 0", i, rd_en); end
      tests_run++; if (rd_addr !== '0) begin tests_failed++; $display("FAIL reset_rd_addr cyc %0d got %0d exp 0", i, rd_addr); end
    end
  endtask

  task automatic test_full_frame();
    int mm, fb, dr;
    for (int i = 0; i < NPIX; i++) ram[i] = 8'(i * 17);
    launch(1);
    record(NREC, -1, 0);
    mm = tx_mismatches(NREC, fb);
    tests_run++; if (mm !== 0) begin tests_failed++; $display("FAIL full_tx_wave bad samples %0d (first at %0d) exp 0", mm, fb); end
    dr = first_done(NREC);
    tests_run++; if (dr !== FRAME_CLKS) begin tests_failed++; $display("FAIL full_done_time got %0d exp %0d", dr, FRAME_CLKS); end
    tests_run++; if (busy_errs(NREC) !== 0) begin tests_failed++; $display("FAIL full_busy bad samples %0d exp 0", busy_errs(NREC)); end
    tests_run++; if (addr_errs() !== 0) begin tests_failed++; $display("FAIL full_rd_addr errors %0d (reads %0d) exp 0 (16)", addr_errs(), addr_q.size()); end
  endtask

  task automatic test_held_start();
    int bad_tx = 0, bad_done = 0;
    record(2000, -1, 0);
    for (int j = 0; j < 2000; j++) begin
      if (tx_s[j] !== 1'b1) bad_tx++;
      if (done_s[j] !== 1'b1) bad_done++;
    end
    tests_run++; if (bad_tx !== 0) begin tests_failed++; $display("FAIL held_tx low samples %0d exp 0", bad_tx); end
    tests_run++; if (bad_done !== 0) begin tests_failed++; $display("FAIL held_done low samples %0d exp 0", bad_done); end
    tests_run++; if (addr_q.size() !== 0) begin tests_failed++; $display("FAIL held_reads got %0d exp 0", addr_q.size()); end
  endtask

  task automatic test_relaunch();
    int mm, fb, dr;
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL relaunch_pre_done got %b exp 1", done); end
    launch(2);
    record(NREC, -1, 0);
    tests_run++; if (done_s[0] !== 1'b0) begin tests_failed++; $display("FAIL relaunch_done_clear got %b exp 0", done_s[0]); end
    mm = tx_mismatches(NREC, fb);
    tests_run++; if (mm !== 0) begin tests_failed++; $display("FAIL relaunch_tx_wave bad samples %0d (first at %0d) exp 0", mm, fb); end
    dr = first_done(NREC);
    tests_run++; if (dr !== FRAME_CLKS) begin tests_failed++; $display("FAIL relaunch_done_time got %0d exp %0d", dr, FRAME_CLKS); end
    tests_run++; if (addr_errs() !== 0) begin tests_failed++; $display("FAIL relaunch_rd_addr errors %0d exp 0", addr_errs()); end
  endtask

  task automatic test_spurious_edge();
    int mm, fb, dr, g_at, g_len;
    for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom_range(0, 255));
    g_at  = $urandom_range(5, FRAME_CLKS - 20);
    g_len = $urandom_range(1, 3);
    launch(2);
    record(NREC, g_at, g_len);
    mm = tx_mismatches(NREC, fb);
    tests_run++; if (mm !== 0) begin tests_failed++; $display("FAIL spurious_tx_wave glitch@%0d bad samples %0d (first at %0d) exp 0", g_at, mm, fb); end
    dr = first_done(NREC);
    tests_run++; if (dr !== FRAME_CLKS) begin tests_failed++; $display("FAIL spurious_done_time got %0d exp %0d", dr, FRAME_CLKS); end
    tests_run++; if (addr_errs() !== 0) begin tests_failed++; $display("FAIL spurious_rd_addr errors %0d (reads %0d) exp 0 (16)", addr_errs(), addr_q.size()); end
  endtask

  task automatic test_random_frames();
    int mm, fb;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom_range(0, 255));
      launch($urandom_range(1, 4));
      record(NREC, -1, 0);
      mm = tx_mismatches(NREC, fb);
      tests_run++; if (mm !== 0) begin tests_failed++; $display("FAIL random_tx_wave frame %0d bad samples %0d (first at %0d) exp 0", k, mm, fb); end
      tests_run++; if (first_done(NREC) !== FRAME_CLKS) begin tests_failed++; $display("FAIL random_done_time got %0d exp %0d", first_done(NREC), FRAME_CLKS); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int jr, mm, fb, bad_done = 0;
    for (int i = 0; i < NPIX; i++) ram[i] = 8'(i * 17);
    // Data bit 3 of byte 5 (0x55 -> bit value 0) is frame bit 4 of that byte
    jr = 3 + 5 * BYTE_CLKS + 4 * CPB + $urandom_range(0, CPB - 1);
    launch(2);
    for (int j = 0; j <= jr; j++) @(negedge clk);
    tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre_tx got %b exp 0", tx); end
    rst = 1'b1;
    start = 1'b0;
    #1;
    tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL midrst_tx got %b exp 1", tx); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1) bad_done++;
    end
    tests_run++; if (bad_done !== 0) begin tests_failed++; $display("FAIL midrst_idle bad samples %0d exp 0", bad_done); end
    launch(1);
    record(NREC, -1, 0);
    tests_run++; if (addr_q.size() == 0 || addr_q[0] !== 0) begin tests_failed++; $display("FAIL midrst_restart_addr got %0d exp 0", addr_q.size() ? addr_q[0] : -1); end
    mm = tx_mismatches(NREC, fb);
    tests_run++; if (mm !== 0) begin tests_failed++; $display("FAIL midrst_tx_wave bad samples %0d (first at %0d) exp 0", mm, fb); end
    tests_run++; if (first_done(NREC) !== FRAME_CLKS) begin tests_failed++; $display("FAIL midrst_done_time got %0d exp %0d", first_done(NREC), FRAME_CLKS); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_held_start();
    test_relaunch();
    test_spurious_edge();
    test_random_frames();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_uart_sender.md
Name: frame_uart_sender

Overview:
- Downstream stage of the 3x3 Gaussian-blur pixel processor.
- Once the processor signals frame completion, this block reads the processed 100x100 8-bit frame from the output RAM in row-major order.
- Streams every pixel over a UART TX line as 8N1 bytes, LSB first.
- Flags completion so top-level control can re-arm the capture path.

Parameters:
- IMG_W, 100, pixels per row
- IMG_H, 100, rows per frame
- ADDR_W, 14, output-RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level from processor's data_process_finish; only a rising edge launches a frame
- rd_en  out  1  output-RAM read enable
- rd_addr  out  ADDR_W  output-RAM read address
- rd_data  in  8  output-RAM read data, valid exactly 1 clk after rd_en/rd_addr are sampled
- tx  out  1  UART serial line, idle high
- busy  out  1  high while a frame is in progress
- done  out  1  sticky frame-complete flag

Behaviour:
- Reset (async): state=IDLE, tx=1, rd_en=0, rd_addr=0, busy=0, done=0, pixel index=0, start_d=0.
- start_d registers start every cycle. Launch condition: start & ~start_d while in IDLE or DONE. Edges in any other state are ignored.
- Pixel index: 0..IMG_W*IMG_H-1, row-major; rd_addr = index.
- FSM states: IDLE, FETCH, WAIT, LOAD, SEND, DONE.
- IDLE -> FETCH on launch: index=0, busy=1, done=0.
- FETCH (1 clk): rd_en=1, rd_addr=index.
- WAIT (1 clk): rd_en=0; RAM presents rd_data.
- LOAD (1 clk): capture rd_data into the serializer and assert its go.
- SEND: serializer drives tx.
  - Start bit (0), then data bits 0..7, then stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT clk.
  - On serializer byte-done: if index == IMG_W*IMG_H-1, go to DONE; else index+1 and go to FETCH.
- DONE: busy=0, done=1, tx=1. done holds until the next launch or rst. A new launch goes directly to FETCH.
- Timing:
  - First start bit begins 3 clk after the launch edge is sampled (FETCH, WAIT, LOAD).
  - Inter-byte gap: exactly 3 clk of tx=1 between the end of a stop bit and the next start bit.
  - Frame duration: IMG_W*IMG_H*(10*CLKS_PER_BIT+3) clk from launch to done rising.
- start held high after done: no retransmission, because there is no new edge.
- rst mid-frame: tx returns high immediately (async) and all state clears. The partial byte is abandoned and no done is issued.
- rd_data is sampled only in LOAD; its value in other cycles is don't-care.
- Width rules:
  - Index comparisons use ADDR_W bits.
  - The bit counter is 4 bits (0..9).
  - The baud counter is clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.

Decomposition:
- Shared package img_pkg holds:
  - IMG_W, IMG_H, ADDR_W, FRAME_PIXELS = IMG_W*IMG_H;
  - the default CLKS_PER_BIT;
  - the FSM state typedef (3-bit encoding).
- One sub-module, uart_tx_byte:
  - parameter CLKS_PER_BIT;
  - ports clk, rst, go, data[7:0], tx, busy, byte_done (1-clk pulse at end of stop bit).
- The top level holds only the frame FSM, the index counter and start-edge detection.

Test Plan:
- Use IMG_W=4, IMG_H=4, CLKS_PER_BIT=4 unless stated; RAM model holds data[i]=i*17.
- Reset state: assert rst 3 clk, release -> tx=1, busy=0, done=0, rd_en=0, rd_addr=0 for 20 clk with start=0.
- Full frame: raise start once -> UART monitor decodes 16 bytes 0x00,0x11,...,0xFF in order. Each start bit is 4 clk wide; gaps are exactly 3 clk. done rises 16*43=688 clk after launch; rd_addr sweeps 0..15.
- Held start: keep start=1 for 2000 clk after done -> no further start bits; done stays 1.
- Re-launch: drop start for 2 clk, raise again -> done clears the next clk and a second identical 16-byte frame is received.
- Reset mid-frame: assert rst during bit 3 of byte 5 -> tx=1 within the same cycle and busy=0. No done. A subsequent launch restarts at rd_addr=0 with byte 0x00.
- Spurious edge: toggle start low/high while busy=1 -> frame is unaffected; byte count stays 16 with no restart.
